// File: rtl/contador_multicanal_pkg.sv
// contador_pkg: shared FSM state type and default channel geometry
package contador_pkg;
  typedef enum logic {IDLE, RUN} estado_t;
  localparam int N_CH_DEF = 2;
  localparam int WIDTH_DEF = 5;
endpackage

// File: rtl/contador_multicanal_if.sv
// contador_multicanal_if: control inputs (start/stop/oneshot/up/clr/max_val) and status outputs (count/wrap/busy/done)
interface contador_multicanal_if
  import contador_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int WIDTH = WIDTH_DEF
);
  logic                    start;
  logic                    stop;
  logic                    oneshot;
  logic                    up;
  logic [N_CH-1:0]         clr;
  logic [N_CH*WIDTH-1:0]   max_val;
  logic [N_CH*WIDTH-1:0]   count;
  logic [N_CH-1:0]         wrap;
  logic                    busy;
  logic                    done;
  modport master (output start, stop, oneshot, up, clr, max_val, input count, wrap, busy, done);
  modport slave  (input start, stop, oneshot, up, clr, max_val, output count, wrap, busy, done);
endinterface

// File: rtl/contador_multicanal_canal.sv
// contador_canal: one modulo channel; in clk/reset/clr/en/up/max_val, out count, wrap_next (comb), wrap (registered)
module contador_canal #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap_next,
  output logic             wrap
);
  logic [WIDTH-1:0] count_d, count_q;
  logic             wrap_d, wrap_q;
  // wrap_next means "would wrap if stepped"; it does not depend on en so the cascade chain has no loop
  always_comb begin
    wrap_next = ~clr & (up ? count_q >= max_val : count_q == '0);
    wrap_d    = en & wrap_next;
    count_d   = clr ? '0 :
                !en ? count_q :
                wrap_next ? (up ? '0 : max_val) :
                up ? count_q + 1'b1 :
                count_q > max_val ? max_val : count_q - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end
  assign count = count_q;
  assign wrap  = wrap_q;
endmodule

// File: rtl/contador_multicanal.sv
// contador_multicanal: run/stop FSM plus enable chain over N_CH modulo channels; ports clk, reset, bus (slave)
module contador_multicanal
  import contador_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CASCADE = 0
) (
  input logic                  clk,
  input logic                  reset,
  contador_multicanal_if.slave bus
);
  estado_t               estado_d, estado_q;
  logic                  done_d, done_q;
  logic                  step;
  logic                  fin;
  logic [N_CH-1:0]       en;
  logic [N_CH-1:0]       wrap_next;
  logic [N_CH-1:0]       wrap_w;
  logic [N_CH*WIDTH-1:0] count_w;
  // stop suppresses the step of the same edge
  always_comb begin
    step = (estado_q == RUN) & ~bus.stop;
    en[0] = step;
    for (int i = 1; i < N_CH; i++) en[i] = (CASCADE != 0) ? en[i-1] & wrap_next[i-1] : step;
    fin    = bus.oneshot & en[N_CH-1] & wrap_next[N_CH-1];
    done_d = fin;
    estado_d = estado_q;
    if (estado_q == IDLE) begin
      if (bus.start & ~bus.stop) estado_d = RUN;
    end else if (bus.stop | fin) begin
      estado_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= IDLE;
      done_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      done_q   <= done_d;
    end
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    contador_canal #(.WIDTH(WIDTH)) u_canal (
      .clk       (clk),
      .reset     (reset),
      .clr       (bus.clr[c]),
      .en        (en[c]),
      .up        (bus.up),
      .max_val   (bus.max_val[c*WIDTH +: WIDTH]),
      .count     (count_w[c*WIDTH +: WIDTH]),
      .wrap_next (wrap_next[c]),
      .wrap      (wrap_w[c])
    );
  end
  assign bus.count = count_w;
  assign bus.wrap  = wrap_w;
  assign bus.busy  = (estado_q == RUN);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_contador_multicanal.sv
// tb_contador_multicanal: independent and cascaded instances against a behavioural model, directed plus random stimulus
module tb_contador_multicanal;
  localparam int N = 2;
  localparam int W = 5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, oneshot = 1'b0, up = 1'b1;
  logic [N-1:0] clr = '0;
  logic [N*W-1:0] max_val = '0;
  int tests = 0, fails = 0;
  bit chk = 1'b0;
  int mc[2][N];
  bit mw[2][N];
  bit mb[2], md[2];

  contador_multicanal_if #(.N_CH(N), .WIDTH(W)) bus0 ();
  contador_multicanal_if #(.N_CH(N), .WIDTH(W)) bus1 ();
  assign bus0.start = start;   assign bus1.start = start;
  assign bus0.stop = stop;     assign bus1.stop = stop;
  assign bus0.oneshot = oneshot; assign bus1.oneshot = oneshot;
  assign bus0.up = up;         assign bus1.up = up;
  assign bus0.clr = clr;       assign bus1.clr = clr;
  assign bus0.max_val = max_val; assign bus1.max_val = max_val;

  contador_multicanal #(.N_CH(N), .WIDTH(W), .CASCADE(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  contador_multicanal #(.N_CH(N), .WIDTH(W), .CASCADE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] dut_v, input int mod_v, input int exp);
    cmp({nm, "_dut"}, dut_v, exp);
    cmp({nm, "_model"}, mod_v, exp);
  endtask

  // Reference: each edge, RUN steps channel 0; the other channels step every RUN cycle,
  // or in cascade only when their lower neighbour stepped and wrapped.
  always @(posedge clk) begin
    bit stepping, carry, en, w;
    int m;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int i = 0; i < N; i++) begin mc[d][i] = 0; mw[d][i] = 0; end
        mb[d] = 0; md[d] = 0;
      end else begin
        stepping = mb[d] && !stop;
        carry = stepping;
        for (int i = 0; i < N; i++) begin
          en = (d == 1 && i > 0) ? carry : stepping;
          m = int'(max_val[i*W +: W]);
          w = 0;
          if (clr[i]) mc[d][i] = 0;
          else if (en) begin
            if (up) begin
              if (mc[d][i] >= m) begin mc[d][i] = 0; w = 1; end
              else mc[d][i] = mc[d][i] + 1;
            end else begin
              if (mc[d][i] == 0) begin mc[d][i] = m; w = 1; end
              else if (mc[d][i] > m) mc[d][i] = m;
              else mc[d][i] = mc[d][i] - 1;
            end
          end
          mw[d][i] = w;
          carry = en && w;
        end
        md[d] = oneshot && mw[d][N-1];
        if (!mb[d]) mb[d] = start && !stop;
        else if (stop || md[d]) mb[d] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      for (int i = 0; i < N; i++) begin
        cmp("count0", 32'(bus0.count[i*W +: W]), mc[0][i]);
        cmp("wrap0", 32'(bus0.wrap[i]), 32'(mw[0][i]));
        cmp("count1", 32'(bus1.count[i*W +: W]), mc[1][i]);
        cmp("wrap1", 32'(bus1.wrap[i]), 32'(mw[1][i]));
      end
      cmp("busy0", 32'(bus0.busy), 32'(mb[0]));
      cmp("done0", 32'(bus0.done), 32'(md[0]));
      cmp("busy1", 32'(bus1.busy), 32'(mb[1]));
      cmp("done1", 32'(bus1.done), 32'(md[1]));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic clear_all();
    clr = '1; tick(); clr = '0;
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    chk = 1'b1;
    lit("rst_busy", 32'(bus0.busy), int'(mb[0]), 0);
    lit("rst_cnt", 32'(bus1.count), mc[1][0] + mc[1][1], 0);
    max_val = {5'd27, 5'd12};
    up = 1'b1;
    pulse_start();
    lit("start_busy", 32'(bus0.busy), int'(mb[0]), 1);
    lit("start_cnt0", 32'(bus0.count[4:0]), mc[0][0], 0);
    tick(12);
    lit("up_ch0_12", 32'(bus0.count[4:0]), mc[0][0], 12);
    tick();
    lit("up_ch0_wrapval", 32'(bus0.count[4:0]), mc[0][0], 0);
    lit("up_ch0_wrap", 32'(bus0.wrap[0]), int'(mw[0][0]), 1);
    tick(15);
    lit("up_ch1_wrapval", 32'(bus0.count[9:5]), mc[0][1], 0);
    lit("up_ch1_wrap", 32'(bus0.wrap[1]), int'(mw[0][1]), 1);
    pulse_stop();
    lit("stop_busy", 32'(bus0.busy), int'(mb[0]), 0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    lit("startstop_busy", 32'(bus0.busy), int'(mb[0]), 0);
    clear_all();
    pulse_start();
    tick(7);
    pulse_stop();
    lit("stop_hold7", 32'(bus0.count[4:0]), mc[0][0], 7);
    tick();
    lit("idle_hold7", 32'(bus0.count[4:0]), mc[0][0], 7);
    clear_all();
    pulse_start();
    tick(12);
    clr = 2'b01; tick(); clr = '0;
    lit("clr_cnt", 32'(bus0.count[4:0]), mc[0][0], 0);
    lit("clr_nowrap", 32'(bus0.wrap[0]), int'(mw[0][0]), 0);
    pulse_stop();
    up = 1'b0;
    max_val = {5'd27, 5'd5};
    clear_all();
    pulse_start();
    tick();
    lit("down_first", 32'(bus0.count[4:0]), mc[0][0], 5);
    lit("down_wrap", 32'(bus0.wrap[0]), int'(mw[0][0]), 1);
    tick();
    lit("down_4", 32'(bus0.count[4:0]), mc[0][0], 4);
    max_val = {5'd27, 5'd2};
    tick();
    lit("down_clamp", 32'(bus0.count[4:0]), mc[0][0], 2);
    lit("down_clamp_nowrap", 32'(bus0.wrap[0]), int'(mw[0][0]), 0);
    pulse_stop();
    up = 1'b1;
    max_val = {5'd3, 5'd2};
    clear_all();
    oneshot = 1'b1;
    pulse_start();
    tick(3);
    lit("casc_ch1_1", 32'(bus1.count[9:5]), mc[1][1], 1);
    tick(9);
    lit("os_cnt", 32'(bus1.count), mc[1][0] + mc[1][1], 0);
    lit("os_done", 32'(bus1.done), int'(md[1]), 1);
    lit("os_busy", 32'(bus1.busy), int'(mb[1]), 0);
    tick();
    lit("os_done_drop", 32'(bus1.done), int'(md[1]), 0);
    lit("os_hold", 32'(bus1.count), mc[1][0] + mc[1][1], 0);
    oneshot = 1'b0;
    max_val = {5'd27, 5'd12};
    clear_all();
    pulse_start();
    tick(9);
    lit("pre_rst_9", 32'(bus0.count[4:0]), mc[0][0], 9);
    reset = 1'b1; tick(); reset = 1'b0;
    lit("rst_run_cnt", 32'(bus0.count), mc[0][0] + mc[0][1], 0);
    lit("rst_run_busy", 32'(bus0.busy), int'(mb[0]), 0);
    pulse_start();
    tick();
    lit("resume_1", 32'(bus0.count[4:0]), mc[0][0], 1);
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(99) == 0);
      start = ($urandom_range(7) == 0);
      stop = ($urandom_range(19) == 0);
      oneshot = ($urandom_range(3) == 0);
      if ($urandom_range(24) == 0) up = ~up;
      clr = ($urandom_range(15) == 0) ? N'($urandom) : '0;
      if ($urandom_range(29) == 0)
        max_val = ($urandom_range(1) == 0) ? (N*W)'($urandom) : {5'($urandom_range(3)), 5'($urandom_range(3))};
      tick();
    end
    reset = 1'b0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/contador_multicanal.md
# contador_multicanal

Parametrised multi-channel modulo counter with a run/stop controller, per-channel programmable terminal values, up/down direction, optional cascading and one-shot mode. It is the general-purpose event and timer counter for the ISL datapath, replacing fixed-width single-purpose counters. All channels share one clock, one reset and one run controller.

## Interface
- N_CH, 2: number of counter channels (≥1)
- WIDTH, 5: bits per channel count
- CASCADE, 0: 0 = all channels step every RUN cycle; 1 = channel i steps only when channel i-1 wraps in the same cycle

Ports (clock and reset first):
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; IDLE→RUN
- stop  in  1  pulse; RUN→IDLE
- oneshot  in  1  1 = stop automatically when channel N_CH-1 wraps
- up  in  1  1 = count up, 0 = count down; applies to all channels
- clr  in  N_CH  per-channel synchronous clear to 0
- max_val  in  N_CH*WIDTH  per-channel terminal value; channel i uses bits [i*WIDTH +: WIDTH]
- count  out  N_CH*WIDTH  per-channel count, same packing
- wrap  out  N_CH  per-channel wrap flag, high for one cycle
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on one-shot completion

## Operation
- FSM states: IDLE, RUN.
  - IDLE→RUN on start.
  - RUN→IDLE on stop, or on a one-shot completion (oneshot=1 and channel N_CH-1 wraps).
  - start in RUN: ignored. stop in IDLE: ignored. start and stop in the same cycle: stop wins, so IDLE stays IDLE.
- Step enable: channel 0 steps in every RUN cycle. Channel i>0 steps in every RUN cycle when CASCADE=0, and when channel i-1 steps and wraps in that cycle when CASCADE=1. The enable chain is combinational and settles within one cycle.
- Up-step:
  - count ≥ max_val: count←0, wrap.
  - Otherwise: count←count+1.
- Down-step:
  - count=0: count←max_val, wrap.
  - count>max_val: count←max_val, no wrap.
  - Otherwise: count←count-1.
- All arithmetic is unsigned, WIDTH bits, with no overflow beyond max_val. max_val=0 wraps on every step.
- Priority per channel: reset > clr > step. A cleared channel does not step and does not wrap in that cycle. When CASCADE=1, it also produces no carry to the next channel.
- Counts hold in IDLE. Counts are not cleared by start or stop.
- One-shot stop takes effect on the completion step itself: counts show the wrapped values and no further step occurs.

## Timing
- Reset values: count=0 for all channels, wrap=0, busy=0, done=0, FSM=IDLE.
- start sampled at edge k: busy=1 after edge k; first step at edge k+1.
- stop sampled at edge k: the step at edge k is suppressed, and busy=0 after edge k.
- wrap and done are registered. They are high for exactly the cycle in which count shows the wrapped value.
- done and busy change on the same edge: done=1 and busy=0 after the completion edge.
- Reset mid-RUN: takes effect on the next edge; all outputs go to their reset values, with no done pulse.
- max_val changes take effect on the next step with no internal latching.

## Structure
- Package contador_pkg holds:
  - typedef enum logic {IDLE, RUN} estado_t
  - default constants N_CH_DEF=2, WIDTH_DEF=5
- Sub-module contador_canal: one channel. Inputs clk, reset, clr, en, up, max_val; outputs count, wrap_next (combinational, for the cascade) and wrap (registered).
- The top level holds the FSM and the enable chain, and instantiates contador_canal N_CH times in a generate loop.

## Test plan
- Independent up-count: N_CH=2, WIDTH=5, CASCADE=0, max_val={27,12}, start pulse.
  - ch0 runs 0..12 then 0, with wrap[0] on the cycle showing 0 after 13 steps.
  - ch1 runs 0..27 then 0, with wrap[1] after 28 steps.
- Cascade one-shot: CASCADE=1, max_val={3,2}, oneshot=1, start.
  - ch0 cycles 0,1,2,0.
  - ch1 increments once per ch0 wrap.
  - After 12 steps both show 0, done=1 for one cycle, busy=0, and counts hold afterward.
- Down-count: up=0, max_val[0]=5, count preloaded to 0 by clr, then start.
  - Sequence is 5,4,3,2,1,0,5 with wrap when 5 appears.
  - Lowering max_val to 2 while count=4 gives next value 2 with no wrap.
- Control conflicts:
  - start+stop together in IDLE: busy stays 0.
  - stop at count=7: count holds 7.
  - clr[0] together with a step at count=12 (max 12): count=0, wrap[0]=0.
- Reset mid-run: reset at ch0=9 during RUN gives all counts 0, busy=0, wrap=0 and done=0 on the next cycle; start afterwards resumes counting from 0.
